// File: rtl/aes_gf_pkg.sv
// GF(2^8) arithmetic and shared widths for the AES MixColumns datapath.
// Multiplies by the MixColumns constants are xtime chains, so they stay pure XOR trees.
package aes_gf_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;
    localparam int         COL_W    = 32;
    localparam int         STATE_W  = 128;
    localparam int         COLS     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (AES_POLY & {8{a[7]}});
    endfunction

    function automatic logic [7:0] x2(input logic [7:0] a);
        return xtime(a);
    endfunction

    function automatic logic [7:0] x3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

    // 9/b/d/e share the x2, x4, x8 chain: 9=8+1, b=8+2+1, d=8+4+1, e=8+4+2
    function automatic logic [7:0] x9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] xb(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] xd(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] xe(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

endpackage

// File: rtl/mix_columns_engine_if.sv
// Input/output handshake bundle of the MixColumns engine; master = producer/consumer side.
interface mix_columns_engine_if;
    import aes_gf_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic               in_inv;
    logic [STATE_W-1:0] in_state;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_state;

    modport master (
        output in_valid, in_inv, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_inv, in_state, out_ready,
        output in_ready, out_valid, out_state
    );

endinterface

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column, byte 0 in the MSBs.
// With INV_EN=0 only the forward XOR tree is built and inv_i is ignored.
module mix_column_word
    import aes_gf_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic [COL_W-1:0] col_i,
    input  logic             inv_i,
    output logic [COL_W-1:0] col_o
);

    logic [7:0]       b0, b1, b2, b3;
    logic [COL_W-1:0] fwd_col;

    assign {b0, b1, b2, b3} = col_i;

    assign fwd_col = {
        x2(b0) ^ x3(b1) ^ b2     ^ b3,
        b0     ^ x2(b1) ^ x3(b2) ^ b3,
        b0     ^ b1     ^ x2(b2) ^ x3(b3),
        x3(b0) ^ b1     ^ b2     ^ x2(b3)
    };

    generate
        if (INV_EN) begin : g_inv
            logic [COL_W-1:0] inv_col;

            assign inv_col = {
                xe(b0) ^ xb(b1) ^ xd(b2) ^ x9(b3),
                x9(b0) ^ xe(b1) ^ xb(b2) ^ xd(b3),
                xd(b0) ^ x9(b1) ^ xe(b2) ^ xb(b3),
                xb(b0) ^ xd(b1) ^ x9(b2) ^ xe(b3)
            };
            assign col_o = inv_i ? inv_col : fwd_col;
        end else begin : g_fwd
            logic unused_inv;

            assign unused_inv = inv_i;
            assign col_o      = fwd_col;
        end
    endgenerate

endmodule

// File: rtl/mix_columns_engine.sv
// Multi-cycle MixColumns engine: COLS_PER_CYCLE columns per clock, result 4/CPC cycles after accept.
// Holds the result until out_ready; a new state is taken in the same cycle the old one leaves.
module mix_columns_engine
    import aes_gf_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INV_EN         = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    mix_columns_engine_if.slave  bus,
    output logic                 busy_o
);

    localparam int GROUPS = COLS / COLS_PER_CYCLE;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    mc_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] work_q, work_d;
    logic               mode_q, mode_d;

    logic               in_ready;
    logic               accept;
    logic               last_group;

    logic [6:0]         col_base [COLS_PER_CYCLE];
    logic [COL_W-1:0]   col_in   [COLS_PER_CYCLE];
    logic [COL_W-1:0]   col_out  [COLS_PER_CYCLE];

    // Column c lives at bits [(3-c)*32 +: 32]; group k covers columns k*CPC .. k*CPC+CPC-1
    always_comb begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            col_base[g] = 7'((COLS - 1 - (int'(cnt_q) * COLS_PER_CYCLE + g)) * COL_W);
            col_in[g]   = work_q[col_base[g] +: COL_W];
        end
    end

    generate
        for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
            mix_column_word #(
                .INV_EN (INV_EN)
            ) u_word (
                .col_i (col_in[g]),
                .inv_i (mode_q),
                .col_o (col_out[g])
            );
        end
    endgenerate

    // Gated by reset so the producer never sees ready while the engine is held in reset
    assign in_ready   = !reset_i &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE && bus.out_ready));
    assign accept     = bus.in_valid && in_ready;
    assign last_group = (cnt_q == CNT_W'(GROUPS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        mode_d  = mode_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    work_d  = bus.in_state;
                    mode_d  = INV_EN ? bus.in_inv : 1'b0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    work_d[col_base[g] +: COL_W] = col_out[g];
                end
                if (last_group) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    work_d  = bus.in_state;
                    mode_d  = INV_EN ? bus.in_inv : 1'b0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end else if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_state = work_q;
    assign busy_o        = (state_q == ST_CALC);

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: main instance CPC=1/INV_EN=1, plus CPC=2/INV_EN=1 and CPC=4/INV_EN=0,
// checked against a GF(2^8) matrix-product reference model.
module tb_mix_columns_engine;
    import aes_gf_pkg::*;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] COL_IN   = 128'hdb135345c6c6c6c6d4d4d4d52d26314c;
    localparam logic [127:0] COL_OUT  = 128'h8e4da1bcc6c6c6c6d5d5d7d64d7ebdf8;
    localparam int           NRAND    = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    mix_columns_engine_if bus ();
    mix_columns_engine_if bus2 ();
    mix_columns_engine_if bus4 ();

    logic         busy, busy2, busy4;
    logic         s_valid = 1'b0;
    logic         s_inv   = 1'b0;
    logic         s_ready = 1'b0;
    logic [127:0] s_state = '0;

    assign bus2.in_valid  = s_valid;
    assign bus2.in_inv    = s_inv;
    assign bus2.in_state  = s_state;
    assign bus2.out_ready = s_ready;
    assign bus4.in_valid  = s_valid;
    assign bus4.in_inv    = s_inv;
    assign bus4.in_state  = s_state;
    assign bus4.out_ready = s_ready;

    mix_columns_engine #(.COLS_PER_CYCLE(1), .INV_EN(1'b1)) u_dut (
        .clk_i(clk), .reset_i(rst), .bus(bus.slave), .busy_o(busy));
    mix_columns_engine #(.COLS_PER_CYCLE(2), .INV_EN(1'b1)) u_dut2 (
        .clk_i(clk), .reset_i(rst), .bus(bus2.slave), .busy_o(busy2));
    mix_columns_engine #(.COLS_PER_CYCLE(4), .INV_EN(1'b0)) u_dut4 (
        .clk_i(clk), .reset_i(rst), .bus(bus4.slave), .busy_o(busy4));

    // Shift-and-add GF(2^8) product, independent of the xtime-chain constants
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   coef [4];
        logic [7:0]   b    [4];
        logic [7:0]   m;
        logic [127:0] r = '0;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) b[j] = s[127 - 32*c - 8*j -: 8];
            for (int row = 0; row < 4; row++) begin
                m = 8'h00;
                for (int j = 0; j < 4; j++) m ^= gmul(coef[(j - row + 4) % 4], b[j]);
                r[127 - 32*c - 8*row -: 8] = m;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drives one state into the main instance and returns its latency and result; called at a negedge
    task automatic send_state(input logic [127:0] s, input logic inv,
                              output int lat, output logic [127:0] res);
        int w = 0;
        bus.in_valid  = 1'b1;
        bus.in_state  = s;
        bus.in_inv    = inv;
        bus.out_ready = 1'b0;
        #1;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk); #1; w++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk); lat++;
        end
        res = bus.out_state;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vecs++; if (bus.out_state !== 128'h0) begin errs++; $display("FAIL reset_out_state: got %h expected 0", bus.out_state); end
        rst = 1'b0;
        #1;
        vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_known_vectors();
        int           lat;
        logic [127:0] res;
        send_state(COL_IN, 1'b0, lat, res);
        vecs++; if (res !== COL_OUT) begin errs++; $display("FAIL fwd_columns: got %h expected %h", res, COL_OUT); end
        vecs++; if (lat !== 4) begin errs++; $display("FAIL fwd_columns_latency: got %0d expected 4", lat); end
        send_state(FIPS_IN, 1'b0, lat, res);
        vecs++; if (res !== FIPS_OUT) begin errs++; $display("FAIL fwd_fips: got %h expected %h", res, FIPS_OUT); end
        vecs++; if (lat !== 4) begin errs++; $display("FAIL fwd_fips_latency: got %0d expected 4", lat); end
        send_state(FIPS_OUT, 1'b1, lat, res);
        vecs++; if (res !== FIPS_IN) begin errs++; $display("FAIL inv_fips: got %h expected %h", res, FIPS_IN); end
        vecs++; if (lat !== 4) begin errs++; $display("FAIL inv_fips_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_cpc_variants();
        logic [127:0] exp2, exp4;
        int           l2, l4;
        for (int pass = 0; pass < 2; pass++) begin
            s_inv   = (pass == 1);
            s_state = (pass == 1) ? FIPS_OUT : FIPS_IN;
            exp2    = (pass == 1) ? FIPS_IN : FIPS_OUT;
            exp4    = ref_mix(s_state, 1'b0);
            s_valid = 1'b1;
            s_ready = 1'b0;
            #1;
            vecs++; if ((bus2.in_ready & bus4.in_ready) !== 1'b1) begin errs++; $display("FAIL cpc_in_ready: got %b%b expected 11", bus2.in_ready, bus4.in_ready); end
            @(posedge clk);
            @(negedge clk);
            s_valid = 1'b0;
            l2 = -1;
            l4 = -1;
            for (int c = 0; c < 10; c++) begin
                if (l2 < 0 && bus2.out_valid) l2 = c;
                if (l4 < 0 && bus4.out_valid) l4 = c;
                @(negedge clk);
            end
            vecs++; if (l2 !== 2) begin errs++; $display("FAIL cpc2_latency: got %0d expected 2", l2); end
            vecs++; if (l4 !== 1) begin errs++; $display("FAIL cpc4_latency: got %0d expected 1", l4); end
            vecs++; if (bus2.out_state !== exp2) begin errs++; $display("FAIL cpc2_result: got %h expected %h", bus2.out_state, exp2); end
            vecs++; if (bus4.out_state !== exp4) begin errs++; $display("FAIL cpc4_fwd_only_result: got %h expected %h", bus4.out_state, exp4); end
            s_ready = 1'b1;
            @(negedge clk);
            s_ready = 1'b0;
            vecs++; if ((bus2.out_valid | bus4.out_valid) !== 1'b0) begin errs++; $display("FAIL cpc_drain: got %b%b expected 00", bus2.out_valid, bus4.out_valid); end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] a = rand_state();
        logic [127:0] b = rand_state();
        logic [127:0] exp_a = ref_mix(a, 1'b0);
        logic [127:0] exp_b = ref_mix(b, 1'b1);
        int           w = 0;
        bus.in_valid = 1'b1; bus.in_state = a; bus.in_inv = 1'b0; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_state = b; bus.in_inv = 1'b1;
        while (!bus.out_valid && w < 20) begin @(negedge clk); w++; end
        for (int c = 0; c < 10; c++) begin
            vecs++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL bp_valid_hold: got %b expected 1", bus.out_valid); end
            vecs++; if (bus.out_state !== exp_a) begin errs++; $display("FAIL bp_state_hold: got %h expected %h", bus.out_state, exp_a); end
            vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        vecs++; if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin errs++; $display("FAIL bp_same_edge_accept: got busy=%b valid=%b expected busy=1 valid=0", busy, bus.out_valid); end
        w = 0;
        while (!bus.out_valid && w < 20) begin @(negedge clk); w++; end
        vecs++; if (w !== 4) begin errs++; $display("FAIL bp_second_latency: got %0d expected 4", w); end
        vecs++; if (bus.out_state !== exp_b) begin errs++; $display("FAIL bp_second_result: got %h expected %h", bus.out_state, exp_b); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        logic [127:0] x = rand_state();
        logic [127:0] res;
        int           lat;
        int           seen = 0;
        bus.in_valid = 1'b1; bus.in_state = rand_state(); bus.in_inv = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL mid_calc_busy: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        vecs++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL mid_calc_reset: got valid=%b busy=%b expected 0 0", bus.out_valid, busy); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        vecs++; if (seen !== 0) begin errs++; $display("FAIL mid_calc_no_output: got %0d outputs expected 0", seen); end
        send_state(x, 1'b0, lat, res);
        vecs++; if (lat !== 4) begin errs++; $display("FAIL post_reset_latency: got %0d expected 4", lat); end
        vecs++; if (res !== ref_mix(x, 1'b0)) begin errs++; $display("FAIL post_reset_result: got %h expected %h", res, ref_mix(x, 1'b0)); end
    endtask

    task automatic test_round_trip();
        logic [127:0] x, y, z;
        int           lat;
        for (int i = 0; i < 20; i++) begin
            x = rand_state();
            send_state(x, 1'b1, lat, y);
            send_state(y, 1'b0, lat, z);
            vecs++; if (z !== x) begin errs++; $display("FAIL round_trip %0d: got %h expected %h", i, z, x); end
        end
    endtask

    task automatic test_random();
        logic [127:0] q[$];
        logic [127:0] exp;
        int           sent = 0;
        int           got  = 0;
        int           cyc  = 0;
        bit           acc  = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        while ((sent < NRAND || q.size() > 0) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (acc) bus.in_valid = 1'b0;
            acc = 1'b0;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid && sent < NRAND && $urandom_range(0, 2) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_state = rand_state();
                bus.in_inv   = 1'($urandom_range(0, 1));
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                vecs++;
                if (q.size() == 0) begin
                    errs++; $display("FAIL rand_extra_output: got %h expected none", bus.out_state);
                end else begin
                    exp = q.pop_front();
                    got++;
                    if (bus.out_state !== exp) begin errs++; $display("FAIL rand_result %0d: got %h expected %h", got, bus.out_state, exp); end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_mix(bus.in_state, bus.in_inv));
                sent++;
                acc = 1'b1;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        vecs++; if (got !== NRAND) begin errs++; $display("FAIL rand_count: got %0d expected %0d (cycles %0d)", got, NRAND, cyc); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_inv    = 1'b0;
        bus.in_state  = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_known_vectors();
        test_cpc_variants();
        test_backpressure();
        test_reset_mid_calc();
        test_round_trip();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
